round_timer_ctrl: RTL and testbench

Match sequencer for the boxing game timer. It owns an internal seconds prescaler (a clock-enable divider of clkin) and steps through the fight and rest periods of a match. Outputs are the current phase, the round number, the seconds remaining and a one-cycle bell pulse, which drive the display and buzzer logic. The prescaler produces a single-cycle enable; no derived clock leaves the block.

---
 rtl/timer_pkg.sv | 12 +
 rtl/sec_prescaler.sv | 49 ++++
 rtl/round_timer_ctrl.sv | 132 +++++++++++++
 tb/tb_round_timer_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the boxing match timer: phase encoding used on the
// phase output and inside the match sequencer.
package timer_pkg;

    typedef enum logic [1:0] {
        PH_IDLE  = 2'b00,
        PH_FIGHT = 2'b01,
        PH_REST  = 2'b10,
        PH_DONE  = 2'b11
    } phase_e;

endpackage

// File: rtl/sec_prescaler.sv
// One-second clock-enable generator: a down-counter that emits a single-cycle
// tick when it reaches one, then reloads. No derived clock is produced.
module sec_prescaler #(
    parameter int TICK_DIV = 50000000,
    parameter int DIV_W    = 30
) (
    input  logic clkin,
    input  logic rst,
    input  logic en,
    input  logic reload,
    output logic tick
);

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             at_one_s;

    assign at_one_s = (cnt_q == DIV_ONE);
    assign tick     = en & at_one_s & ~reload;

    // Next count: reload wins, otherwise count down and wrap at one while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (reload) begin
            cnt_d = DIV_LOAD;
        end else if (en) begin
            if (at_one_s) begin
                cnt_d = DIV_LOAD;
            end else begin
                cnt_d = cnt_q - DIV_ONE;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clkin) begin
        if (rst) begin
            cnt_q <= DIV_LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/round_timer_ctrl.sv
// Match sequencer for the boxing game timer: steps through fight and rest
// periods on one-second ticks and drives phase, round, seconds and bell.
module round_timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICK_DIV   = 50000000,
    parameter int ROUND_SEC  = 180,
    parameter int REST_SEC   = 60,
    parameter int NUM_ROUNDS = 3,
    parameter int DIV_W      = 30,
    parameter int SEC_W      = 8,
    parameter int RND_W      = 4
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic             abort,
    output logic [1:0]       phase,
    output logic [RND_W-1:0] round_num,
    output logic [SEC_W-1:0] sec_left,
    output logic             bell,
    output logic             done
);

    localparam logic [SEC_W-1:0] SEC_ROUND = SEC_W'(ROUND_SEC);
    localparam logic [SEC_W-1:0] SEC_REST  = SEC_W'(REST_SEC);
    localparam logic [SEC_W-1:0] SEC_ONE   = SEC_W'(1);
    localparam logic [SEC_W-1:0] SEC_ZERO  = SEC_W'(0);
    localparam logic [RND_W-1:0] RND_LAST  = RND_W'(NUM_ROUNDS);
    localparam logic [RND_W-1:0] RND_ONE   = RND_W'(1);
    localparam logic [RND_W-1:0] RND_ZERO  = RND_W'(0);

    phase_e           phase_q;
    logic [RND_W-1:0] round_q;
    logic [SEC_W-1:0] sec_q;
    logic             bell_q;
    logic             done_q;

    logic running_s;
    logic pre_en_s;
    logic pre_reload_s;
    logic tick_s;

    // The prescaler only runs inside a period; leaving or aborting a period
    // pins it at full count so every period entry starts a fresh second.
    assign running_s    = (phase_q == PH_FIGHT) || (phase_q == PH_REST);
    assign pre_en_s     = running_s & ~hold;
    assign pre_reload_s = abort | ~running_s;

    sec_prescaler #(
        .TICK_DIV (TICK_DIV),
        .DIV_W    (DIV_W)
    ) u_prescaler (
        .clkin  (clkin),
        .rst    (rst),
        .en     (pre_en_s),
        .reload (pre_reload_s),
        .tick   (tick_s)
    );

    // Match FSM with its registered counters and outputs.
    always_ff @(posedge clkin) begin
        if (rst) begin
            phase_q <= PH_IDLE;
            round_q <= RND_ZERO;
            sec_q   <= SEC_ZERO;
            bell_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort) begin
            phase_q <= PH_IDLE;
            round_q <= RND_ZERO;
            sec_q   <= SEC_ZERO;
            bell_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            bell_q <= 1'b0;
            case (phase_q)
                PH_IDLE, PH_DONE: begin
                    if (start) begin
                        phase_q <= PH_FIGHT;
                        round_q <= RND_ONE;
                        sec_q   <= SEC_ROUND;
                        bell_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                PH_FIGHT: begin
                    if (tick_s) begin
                        if (sec_q > SEC_ONE) begin
                            sec_q <= sec_q - SEC_ONE;
                        end else if (round_q < RND_LAST) begin
                            phase_q <= PH_REST;
                            sec_q   <= SEC_REST;
                            bell_q  <= 1'b1;
                        end else begin
                            phase_q <= PH_DONE;
                            sec_q   <= SEC_ZERO;
                            done_q  <= 1'b1;
                            bell_q  <= 1'b1;
                        end
                    end
                end
                PH_REST: begin
                    if (tick_s) begin
                        if (sec_q > SEC_ONE) begin
                            sec_q <= sec_q - SEC_ONE;
                        end else begin
                            phase_q <= PH_FIGHT;
                            round_q <= round_q + RND_ONE;
                            sec_q   <= SEC_ROUND;
                            bell_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    phase_q <= PH_IDLE;
                    round_q <= RND_ZERO;
                    sec_q   <= SEC_ZERO;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign phase     = phase_q;
    assign round_num = round_q;
    assign sec_left  = sec_q;
    assign bell      = bell_q;
    assign done      = done_q;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Scoreboard bench for round_timer_ctrl with a short match configuration:
// stimulus queues expected output snapshots per cycle, a monitor compares them.
module tb_round_timer_ctrl;

    localparam int TICK_DIV   = 4;
    localparam int ROUND_SEC  = 3;
    localparam int REST_SEC   = 2;
    localparam int NUM_ROUNDS = 2;
    localparam int DIV_W      = 8;
    localparam int SEC_W      = 8;
    localparam int RND_W      = 4;

    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] F = 2'b01;
    localparam logic [1:0] R = 2'b10;
    localparam logic [1:0] D = 2'b11;

    logic             clkin = 1'b0;
    logic             rst;
    logic             start;
    logic             hold;
    logic             abort;
    logic [1:0]       phase;
    logic [RND_W-1:0] round_num;
    logic [SEC_W-1:0] sec_left;
    logic             bell;
    logic             done;

    typedef struct {
        int         cyc;
        logic [1:0] ph;
        logic [3:0] rn;
        logic [7:0] sl;
        logic       bl;
        logic       dn;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   bell_cnt = 0;
    int   e0, e1, e2, e3, bells0;

    round_timer_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .ROUND_SEC  (ROUND_SEC),
        .REST_SEC   (REST_SEC),
        .NUM_ROUNDS (NUM_ROUNDS),
        .DIV_W      (DIV_W),
        .SEC_W      (SEC_W),
        .RND_W      (RND_W)
    ) dut (
        .clkin     (clkin),
        .rst       (rst),
        .start     (start),
        .hold      (hold),
        .abort     (abort),
        .phase     (phase),
        .round_num (round_num),
        .sec_left  (sec_left),
        .bell      (bell),
        .done      (done)
    );

    always #5 clkin = ~clkin;

    // cyc equals the number of the most recent rising edge.
    always @(posedge clkin) cyc <= cyc + 1;

    task automatic push(input int c, input logic [1:0] ph, input int rn,
                        input int sl, input logic bl, input logic dn);
        exp_t e;
        e.cyc = c; e.ph = ph; e.rn = 4'(rn); e.sl = 8'(sl); e.bl = bl; e.dn = dn;
        exp_q.push_back(e);
    endtask

    // Returns at the falling edge following rising edge k.
    task automatic at_cyc(input int k);
        while (cyc != k) @(negedge clkin);
    endtask

    // Monitor: compare the queued snapshot for this cycle just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clkin);
            #1;
            if (bell) bell_cnt++;
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (e.cyc < cyc) begin
                    errors++;
                    $display("FAIL missed_cycle: expectation for edge %0d not sampled (now %0d)", e.cyc, cyc);
                end else if (phase !== e.ph || round_num !== e.rn || sec_left !== e.sl ||
                             bell !== e.bl || done !== e.dn) begin
                    errors++;
                    $display("FAIL edge_%0d: got ph=%0d rn=%0d sl=%0d bell=%0b done=%0b, want ph=%0d rn=%0d sl=%0d bell=%0b done=%0b",
                             cyc, phase, round_num, sec_left, bell, done,
                             e.ph, e.rn, e.sl, e.bl, e.dn);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0;
        push(2, I, 0, 0, 1'b0, 1'b0);
        push(3, I, 0, 0, 1'b0, 1'b0);
        push(5, I, 0, 0, 1'b0, 1'b0);
        at_cyc(3);
        rst = 1'b0;

        // Full two-round match.
        e0 = 6;
        push(e0,      F, 1, 3, 1'b1, 1'b0);
        push(e0 + 1,  F, 1, 3, 1'b0, 1'b0);
        push(e0 + 3,  F, 1, 3, 1'b0, 1'b0);
        push(e0 + 4,  F, 1, 2, 1'b0, 1'b0);
        push(e0 + 8,  F, 1, 1, 1'b0, 1'b0);
        push(e0 + 11, F, 1, 1, 1'b0, 1'b0);
        push(e0 + 12, R, 1, 2, 1'b1, 1'b0);
        push(e0 + 13, R, 1, 2, 1'b0, 1'b0);
        push(e0 + 16, R, 1, 1, 1'b0, 1'b0);
        push(e0 + 20, F, 2, 3, 1'b1, 1'b0);
        push(e0 + 24, F, 2, 2, 1'b0, 1'b0);
        push(e0 + 28, F, 2, 1, 1'b0, 1'b0);
        push(e0 + 32, D, 2, 0, 1'b1, 1'b1);
        push(e0 + 33, D, 2, 0, 1'b0, 1'b1);
        at_cyc(e0 - 1);
        bells0 = bell_cnt;
        start = 1'b1;
        at_cyc(e0);
        start = 1'b0;
        at_cyc(e0 + 33);
        checks++;
        if (bell_cnt - bells0 != 4) begin
            errors++;
            $display("FAIL bell_count: got %0d pulses, want 4", bell_cnt - bells0);
        end

        // Restart from DONE, then a start pulse inside FIGHT that must be ignored.
        e1 = e0 + 34;
        push(e1,      F, 1, 3, 1'b1, 1'b0);
        push(e1 + 4,  F, 1, 2, 1'b0, 1'b0);
        push(e1 + 6,  F, 1, 2, 1'b0, 1'b0);
        push(e1 + 7,  F, 1, 2, 1'b0, 1'b0);
        push(e1 + 8,  F, 1, 1, 1'b0, 1'b0);
        push(e1 + 12, R, 1, 2, 1'b1, 1'b0);
        push(e1 + 13, I, 0, 0, 1'b0, 1'b0);
        start = 1'b1;
        at_cyc(e1);
        start = 1'b0;
        at_cyc(e1 + 5);
        start = 1'b1;
        at_cyc(e1 + 6);
        start = 1'b0;
        at_cyc(e1 + 12);
        abort = 1'b1;
        at_cyc(e1 + 13);
        abort = 1'b0;

        // Hold for five edges in FIGHT, then abort with start mid-REST.
        e2 = e1 + 15;
        push(e2,      F, 1, 3, 1'b1, 1'b0);
        push(e2 + 4,  F, 1, 3, 1'b0, 1'b0);
        push(e2 + 6,  F, 1, 3, 1'b0, 1'b0);
        push(e2 + 8,  F, 1, 3, 1'b0, 1'b0);
        push(e2 + 9,  F, 1, 2, 1'b0, 1'b0);
        push(e2 + 13, F, 1, 1, 1'b0, 1'b0);
        push(e2 + 16, F, 1, 1, 1'b0, 1'b0);
        push(e2 + 17, R, 1, 2, 1'b1, 1'b0);
        push(e2 + 18, R, 1, 2, 1'b0, 1'b0);
        push(e2 + 19, I, 0, 0, 1'b0, 1'b0);
        push(e2 + 20, I, 0, 0, 1'b0, 1'b0);
        push(e2 + 23, I, 0, 0, 1'b0, 1'b0);
        at_cyc(e2 - 1);
        start = 1'b1;
        at_cyc(e2);
        start = 1'b0;
        at_cyc(e2 + 1);
        hold = 1'b1;
        at_cyc(e2 + 6);
        hold = 1'b0;
        at_cyc(e2 + 18);
        abort = 1'b1;
        start = 1'b1;
        at_cyc(e2 + 19);
        abort = 1'b0;
        start = 1'b0;

        // Reset mid-match with start held high, then a clean start afterwards.
        e3 = e2 + 25;
        push(e3,      F, 1, 3, 1'b1, 1'b0);
        push(e3 + 4,  F, 1, 2, 1'b0, 1'b0);
        push(e3 + 8,  F, 1, 1, 1'b0, 1'b0);
        push(e3 + 9,  F, 1, 1, 1'b0, 1'b0);
        push(e3 + 10, I, 0, 0, 1'b0, 1'b0);
        push(e3 + 11, I, 0, 0, 1'b0, 1'b0);
        push(e3 + 12, I, 0, 0, 1'b0, 1'b0);
        push(e3 + 14, F, 1, 3, 1'b1, 1'b0);
        push(e3 + 17, F, 1, 3, 1'b0, 1'b0);
        push(e3 + 18, F, 1, 2, 1'b0, 1'b0);
        at_cyc(e3 - 1);
        start = 1'b1;
        at_cyc(e3);
        start = 1'b0;
        at_cyc(e3 + 9);
        rst = 1'b1;
        start = 1'b1;
        at_cyc(e3 + 11);
        rst = 1'b0;
        start = 1'b0;
        at_cyc(e3 + 13);
        start = 1'b1;
        at_cyc(e3 + 14);
        start = 1'b0;

        at_cyc(e3 + 20);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
